// File: rtl/serial_link.sv
`default_nettype none
// ============================================================================
// Module   : serial_link
// Purpose  : Game Boy link port (SB/SC) with internal 8192 Hz or external
//            shift clock and a one-cycle transfer-complete interrupt request.
// Revision : 1.0 - initial release
// ============================================================================
module serial_link #(
  parameter int CLK_DIV = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        rd,
  input  logic        wr,
  output logic        int_serial_req,
  input  logic        int_serial_ack,
  input  logic        sck_in,
  input  logic        sin,
  output logic        sck_out,
  output logic        sck_oe,
  output logic        sout
);

  localparam int                 c_DIV_W    = $clog2(CLK_DIV);
  localparam logic [c_DIV_W-1:0] c_DIV_HALF = c_DIV_W'(CLK_DIV / 2);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
  localparam logic [15:0]        c_ADDR_SB  = 16'hFF01;
  localparam logic [15:0]        c_ADDR_SC  = 16'hFF02;
  localparam logic [0:0]         c_IDLE     = 1'b0;
  localparam logic [0:0]         c_SHIFT    = 1'b1;

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic [7:0]         r_sb;
  logic               r_start;
  logic               r_clksel;
  logic [2:0]         r_cnt;
  logic [c_DIV_W-1:0] r_div;
  logic               r_sck_out;
  logic               r_sout;
  logic               r_req;
  logic               r_sck_meta;
  logic               r_sck_sync;
  logic               r_sck_prev;
  logic               r_sin_meta;
  logic               r_sin_sync;

  logic w_sb_wr;
  logic w_sc_wr;
  logic w_sck_rise;
  logic w_sck_fall;
  logic w_shift;
  logic w_fall;
  logic w_rise;
  logic w_abort;
  logic w_go;
  logic w_final;
  logic w_stop;
  logic w_unused;

  assign w_sb_wr    = wr && (a == c_ADDR_SB);
  assign w_sc_wr    = wr && (a == c_ADDR_SC);
  assign w_sck_rise = r_sck_sync & ~r_sck_prev;
  assign w_sck_fall = ~r_sck_sync & r_sck_prev;
  assign w_unused   = &{1'b0, rd, int_serial_ack, din[6:1]};

  // Both link inputs are asynchronous; idle-high reset avoids a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_meta <= 1'b1;
      r_sck_sync <= 1'b1;
      r_sck_prev <= 1'b1;
      r_sin_meta <= 1'b1;
      r_sin_sync <= 1'b1;
    end else begin
      r_sck_meta <= sck_in;
      r_sck_sync <= r_sck_meta;
      r_sck_prev <= r_sck_sync;
      r_sin_meta <= sin;
      r_sin_sync <= r_sin_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (w_go)   w_state_nxt = c_SHIFT;
      c_SHIFT: if (w_stop) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Shift-clock edge strobes come from the divider or the synchronized pin.
  always_comb begin
    w_shift = (r_state == c_SHIFT);
    w_fall  = 1'b0;
    w_rise  = 1'b0;
    if (w_shift) begin
      if (r_clksel) begin
        w_fall = (r_div == '0);
        w_rise = (r_div == c_DIV_HALF);
      end else begin
        w_fall = w_sck_fall;
        w_rise = w_sck_rise;
      end
    end
    w_abort = w_shift && w_sc_wr && !din[7];
    w_go    = !w_shift && w_sc_wr && din[7];
    w_final = w_rise && !w_abort && (r_cnt == 3'd7);
    w_stop  = w_abort || w_final;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb      <= 8'h00;
      r_start   <= 1'b0;
      r_clksel  <= 1'b0;
      r_cnt     <= 3'd0;
      r_div     <= '0;
      r_sck_out <= 1'b1;
      r_sout    <= 1'b1;
      r_req     <= 1'b0;
    end else begin
      if (!w_shift && w_sb_wr) begin
        r_sb <= din;
      end else if (w_rise && !w_abort) begin
        r_sb <= {r_sb[6:0], r_sin_sync};
      end

      if (!w_shift && w_sc_wr) begin
        r_start  <= din[7];
        r_clksel <= din[0];
      end else if (w_stop) begin
        r_start <= 1'b0;
      end

      if (w_go) begin
        r_cnt <= 3'd0;
      end else if (w_rise && !w_abort) begin
        r_cnt <= r_cnt + 3'd1;
      end

      if (!w_shift || w_stop || !r_clksel || (r_div == c_DIV_LAST)) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + 1'b1;
      end

      if (w_go) begin
        r_sout <= r_sb[7];
      end else if (w_stop) begin
        r_sout <= 1'b1;
      end else if (w_fall) begin
        r_sout <= r_sb[7];
      end

      // sck_out only toggles when this end owns the clock.
      if (w_stop) begin
        r_sck_out <= 1'b1;
      end else if (r_clksel && w_fall) begin
        r_sck_out <= 1'b0;
      end else if (r_clksel && w_rise) begin
        r_sck_out <= 1'b1;
      end

      r_req <= w_final;
    end
  end

  always_comb begin
    case (a)
      c_ADDR_SB: dout = r_sb;
      c_ADDR_SC: dout = {r_start, 6'b111111, r_clksel};
      default:   dout = 8'hFF;
    endcase
  end

  assign sck_out        = r_sck_out;
  assign sck_oe         = r_clksel;
  assign sout           = r_sout;
  assign int_serial_req = r_req;

endmodule
`default_nettype wire

// File: tb/tb_serial_link.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_link
// Purpose  : Scoreboard bench for serial_link with randomized transfers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_link;

  localparam int D   = 8;
  localparam int LAT = 7 * D + D / 2 + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a = 16'hFF01;
  logic [7:0]  din = 8'h00;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic        ack = 1'b0;
  logic        sck_in = 1'b1;
  logic        sin_drv = 1'b1;
  logic        loopback = 1'b0;
  logic        sin;
  logic [7:0]  dout;
  logic        int_serial_req;
  logic        sck_out;
  logic        sck_oe;
  logic        sout;

  assign sin = loopback ? sout : sin_drv;

  serial_link #(.CLK_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .din(din), .dout(dout), .rd(rd), .wr(wr),
    .int_serial_req(int_serial_req), .int_serial_ack(ack),
    .sck_in(sck_in), .sin(sin), .sck_out(sck_out), .sck_oe(sck_oe), .sout(sout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] sb;
    bit         ext;
    int         t0;
  } exp_t;

  exp_t exp_q[$];
  bit   sout_q[$];
  int   checks = 0;
  int   passes = 0;
  int   npulses = 0;
  int   t_rise = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [7:0] v);
    a = addr; rd = 1'b1;
    #1 v = dout;
    a = 16'hFF01; rd = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
    a = addr; din = data; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0; din = 8'h00; a = 16'hFF01;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_req(input int target, input int budget);
    int n = 0;
    while (npulses < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", npulses >= target, 1);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: every request pulse must match the oldest expected transfer.
  initial begin
    bit   pend = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (pend) begin
        check("req_width", int_serial_req, 0);
        check("sb_at_done", dout, e.sb);
        pend = 1'b0;
      end else if (rst_n && int_serial_req) begin
        npulses++;
        check("req_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          pend = 1'b1;
          if (e.ext) check("ext_req_window", (cyc - t_rise >= 1) && (cyc - t_rise <= 4), 1);
          else       check("req_latency", cyc - e.t0, LAT);
        end
      end
    end
  end

  // Records sout at each falling edge of the internally generated clock.
  initial begin
    bit prev = 1'b1;
    forever begin
      @(negedge clk);
      #2;
      if (prev && !sck_out) sout_q.push_back(sout);
      prev = sck_out;
    end
  end

  task automatic run_internal(input logic [7:0] sb, input bit loop, input bit wr_final);
    int t0;
    int np;
    logic [7:0] v;
    logic [7:0] seq;
    np = npulses;
    loopback = loop;
    sin_drv = 1'b1;
    bus_write(16'hFF01, sb);
    sout_q.delete();
    t0 = cyc;
    exp_q.push_back('{loop ? sb : 8'hFF, 1'b0, t0});
    bus_write(16'hFF02, 8'h81);
    wait_cyc(t0 + 10);
    bus_read(16'hFF02, v);
    check("sc_busy", v, 8'hFF);
    if (wr_final) begin
      wait_cyc(t0 + LAT - 1);
      bus_write(16'hFF01, 8'h00);
    end
    wait_req(np + 1, LAT + 40);
    bus_read(16'hFF02, v);
    check("sc_done_int", v, 8'h7F);
    check("sout_count", sout_q.size(), 8);
    seq = 8'h00;
    foreach (sout_q[i]) seq = 8'((seq * 2) + sout_q[i]);
    check("sout_seq", seq, sb);
    loopback = 1'b0;
  endtask

  task automatic run_external(input logic [7:0] sb, input logic [7:0] bits);
    int t0;
    int np;
    logic [7:0] v;
    logic [7:0] e;
    np = npulses;
    bus_write(16'hFF01, sb);
    t0 = cyc;
    bus_write(16'hFF02, 8'h80);
    e = 8'h00;
    for (int i = 0; i < 8; i++) e = 8'((e * 2) + bits[7 - i]);
    exp_q.push_back('{e, 1'b1, t0});
    for (int i = 0; i < 8; i++) begin
      sck_in = 1'b0;
      sin_drv = bits[7 - i];
      repeat (20) @(negedge clk);
      sck_in = 1'b1;
      t_rise = cyc;
      if (i == 6) begin
        repeat (20) @(negedge clk);
        check("no_req_after_7", npulses, np);
      end else if (i < 7) begin
        repeat (20) @(negedge clk);
      end
    end
    wait_req(np + 1, 40);
    bus_read(16'hFF02, v);
    check("sc_done_ext", v, 8'h7E);
    check("sck_oe_ext", sck_oe, 0);
    sin_drv = 1'b1;
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] sb;
    int t0;
    int np;

    repeat (3) @(negedge clk);
    #1 check("rst_sck_out", sck_out, 1);
    check("rst_sout", sout, 1);
    check("rst_sck_oe", sck_oe, 0);
    check("rst_req", int_serial_req, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_read(16'hFF01, v);
    check("rst_sb", v, 8'h00);
    bus_read(16'hFF02, v);
    check("rst_sc", v, 8'h7E);
    bus_read(16'h1234, v);
    check("unmapped_read", v, 8'hFF);

    // Link clock edges while idle must not disturb SB.
    for (int i = 0; i < 4; i++) begin
      sck_in = ~sck_in;
      sin_drv = 1'(i);
      repeat (10) @(negedge clk);
    end
    sck_in = 1'b1;
    sin_drv = 1'b1;
    repeat (4) @(negedge clk);
    bus_read(16'hFF01, v);
    check("idle_edges_ignored", v, 8'h00);
    check("idle_no_req", npulses, 0);

    for (int i = 0; i < 3; i++) run_internal((i == 0) ? 8'hA5 : 8'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) run_internal((i == 0) ? 8'h3C : 8'($urandom), 1'b0, i == 2);
    run_external(8'h0F, 8'b0110_0101);
    run_external(8'($urandom), 8'($urandom));

    // Abort after three bits; the SB write mid-transfer must be ignored.
    np = npulses;
    sb = 8'($urandom);
    bus_write(16'hFF01, sb);
    t0 = cyc;
    bus_write(16'hFF02, 8'h81);
    wait_cyc(t0 + 5);
    bus_write(16'hFF01, 8'h00);
    wait_cyc(t0 + 3 * D + 2);
    bus_write(16'hFF02, 8'h01);
    repeat (LAT + 10) @(negedge clk);
    check("abort_no_req", npulses, np);
    bus_read(16'hFF02, v);
    check("abort_sc", v, 8'h7F);
    bus_read(16'hFF01, v);
    check("abort_sb_partial", v, 8'((sb * 8) + 7));
    check("abort_sout", sout, 1);
    check("abort_sck_out", sck_out, 1);

    // Asynchronous reset after four bits.
    np = npulses;
    bus_write(16'hFF01, 8'($urandom));
    t0 = cyc;
    bus_write(16'hFF02, 8'h81);
    wait_cyc(t0 + 4 * D + 2);
    rst_n = 1'b0;
    #1 check("mid_rst_sck_out", sck_out, 1);
    check("mid_rst_sout", sout, 1);
    check("mid_rst_sck_oe", sck_oe, 0);
    check("mid_rst_req", int_serial_req, 0);
    bus_read(16'hFF01, v);
    check("mid_rst_sb", v, 8'h00);
    bus_read(16'hFF02, v);
    check("mid_rst_sc", v, 8'h7E);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 10) @(negedge clk);
    check("mid_rst_no_req", npulses, np);

    // New start written on the very cycle the request pulse is high.
    np = npulses;
    loopback = 1'b1;
    sb = 8'($urandom);
    bus_write(16'hFF01, sb);
    t0 = cyc;
    exp_q.push_back('{sb, 1'b0, t0});
    bus_write(16'hFF02, 8'h81);
    wait_cyc(t0 + LAT);
    check("restart_on_req_cycle", int_serial_req, 1);
    exp_q.push_back('{sb, 1'b0, cyc});
    bus_write(16'hFF02, 8'h81);
    wait_req(np + 2, LAT + 40);
    bus_read(16'hFF02, v);
    check("restart_sc", v, 8'h7F);
    loopback = 1'b0;

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
